// File: rtl/addac_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : addac_seq_if
// Description : Command, datapath-control and result bus of the addac_seq
//               accumulator sequencer. The master side issues commands and
//               hosts the 4-bit accumulator datapath. The slave side is the
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface addac_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic [3:0] dp_a;
  logic       dp_sel0;
  logic       dp_sel1;
  logic [3:0] dp_s;
  logic       dp_cout;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ovf;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, dp_s, dp_cout,
    input  cmd_ready, dp_a, dp_sel0, dp_sel1, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, dp_s, dp_cout,
    output cmd_ready, dp_a, dp_sel0, dp_sel1, res_valid, res_data, res_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/addac_seq.sv
`default_nettype none
// ============================================================================
// Module      : addac_seq
// Description : Command sequencer for an external 4-bit accumulator datapath.
//               It accepts LOAD/ADD/SUB/CLEAR commands and repeats ADD/SUB
//               up to 7 times. It tracks a sticky carry/borrow flag and
//               strobes the final accumulator value for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module addac_seq (
  input  wire logic   clk,
  input  wire logic   rst,
  addac_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_OP_LOAD  = 2'b00;
  localparam logic [1:0] C_OP_ADD   = 2'b01;
  localparam logic [1:0] C_OP_SUB   = 2'b10;
  localparam logic [1:0] C_OP_CLEAR = 2'b11;

  localparam logic [1:0] C_SEL_HOLD = 2'b00;
  localparam logic [1:0] C_SEL_LOAD = 2'b01;
  localparam logic [1:0] C_SEL_ADD  = 2'b10;
  localparam logic [1:0] C_SEL_SUB  = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [3:0] r_data;
  logic [2:0] r_cnt;
  logic       r_ovf;

  logic       w_ready;
  logic       w_accept;
  logic       w_cmd_arith;
  logic [1:0] w_sel;
  logic [3:0] w_dp_a;
  logic       w_res_valid;
  logic [3:0] w_res_data;
  logic       w_res_ovf;
  logic       w_busy;

  // The ready signal is held low while reset is asserted, not only after the state register clears.
  assign w_ready     = (r_state == S_IDLE) && !rst;
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_cmd_arith = (bus.cmd_op == C_OP_ADD) || (bus.cmd_op == C_OP_SUB);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath/result control decode
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = C_SEL_HOLD;
    w_dp_a      = 4'd0;
    w_res_valid = 1'b0;
    w_res_data  = 4'd0;
    w_res_ovf   = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          // A zero repeat count for ADD/SUB skips the datapath entirely
          if (w_cmd_arith && (bus.cmd_cnt == 3'd0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        case (r_op)
          C_OP_ADD:   w_sel = C_SEL_ADD;
          C_OP_SUB:   w_sel = C_SEL_SUB;
          default:    w_sel = C_SEL_LOAD;
        endcase
        w_dp_a = (r_op == C_OP_CLEAR) ? 4'd0 : r_data;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        w_res_data  = bus.dp_s;
        w_res_ovf   = r_ovf;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command capture, iteration counting and sticky overflow tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= 2'd0;
      r_data <= 4'd0;
      r_cnt  <= 3'd0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_data <= bus.cmd_data;
            r_cnt  <= w_cmd_arith ? bus.cmd_cnt : 3'd1;
            r_ovf  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end
          // ADD overflows on carry-out; SUB borrows when the carry-out is clear
          if (((r_op == C_OP_ADD) && bus.dp_cout) ||
              ((r_op == C_OP_SUB) && !bus.dp_cout)) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.dp_sel1   = w_sel[1];
  assign bus.dp_sel0   = w_sel[0];
  assign bus.dp_a      = w_dp_a;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_data;
  assign bus.res_ovf   = w_res_ovf;
  assign bus.busy      = w_busy;

  // C_OP_LOAD is implied by the default branch of the sel decode
  logic w_unused;
  assign w_unused = ^{C_OP_LOAD};

endmodule
`default_nettype wire

// File: tb/tb_addac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addac_seq
// Description : Directed self-checking bench for addac_seq with a behavioural
//               4-bit accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addac_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  addac_seq_if bus();

  addac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: accumulator is not affected by rst
  logic [3:0] acc = 4'd0;
  logic [4:0] w_sum;
  always_comb begin
    w_sum = {1'b0, acc};
    case ({bus.dp_sel1, bus.dp_sel0})
      2'b01:   w_sum = {1'b0, bus.dp_a};
      2'b10:   w_sum = {1'b0, acc} + {1'b0, bus.dp_a};
      2'b11:   w_sum = {1'b0, acc} + {1'b0, ~bus.dp_a} + 5'd1;
      default: w_sum = {1'b0, acc};
    endcase
  end
  assign bus.dp_cout = w_sum[4];
  assign bus.dp_s    = acc;
  always @(posedge clk) acc <= w_sum[3:0];

  // Issue one command and observe it until its result strobe (bounded)
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c,
                         input logic [1:0] esel, input logic [3:0] ea,
                         output int nrun, output int nbad, output int ncyc,
                         output bit done, output logic [3:0] rd, output logic ro);
    nrun = 0; nbad = 0; ncyc = 0; done = 1'b0; rd = 4'hx; ro = 1'bx;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d; bus.cmd_cnt = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      ncyc++;
      if ({bus.dp_sel1, bus.dp_sel0} != 2'b00) begin
        nrun++;
        if ({bus.dp_sel1, bus.dp_sel0} !== esel || bus.dp_a !== ea) nbad++;
      end
      if (bus.res_valid === 1'b1) begin
        done = 1'b1; rd = bus.res_data; ro = bus.res_ovf;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", bus.cmd_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_checks++; if ({bus.dp_sel1, bus.dp_sel0} !== 2'b00) begin n_fail++; $display("FAIL rst_sel got=%b exp=00", {bus.dp_sel1, bus.dp_sel0}); end
    n_checks++; if (bus.dp_a !== 4'd0) begin n_fail++; $display("FAIL rst_dp_a got=%h exp=0", bus.dp_a); end
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_res got=%b%b exp=00", bus.res_valid, bus.res_ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_clear_add();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    run_cmd(2'b11, 4'hA, 3'd5, 2'b01, 4'd0, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 1 || nbad != 0 || rd !== 4'd0 || ro !== 1'b0) begin n_fail++;
      $display("FAIL clear done=%0d nrun=%0d nbad=%0d rd=%h ro=%b exp 1/1/0/0/0", done, nrun, nbad, rd, ro); end
    run_cmd(2'b01, 4'd3, 3'd4, 2'b10, 4'd3, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 4 || nbad != 0 || ncyc != 5) begin n_fail++;
      $display("FAIL add3x4_timing done=%0d nrun=%0d nbad=%0d ncyc=%0d exp 1/4/0/5", done, nrun, nbad, ncyc); end
    n_checks++; if (rd !== 4'd12 || ro !== 1'b0) begin n_fail++; $display("FAIL add3x4_res rd=%h ro=%b exp c/0", rd, ro); end
  endtask

  task automatic test_sub_borrow();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    run_cmd(2'b00, 4'd5, 3'd6, 2'b01, 4'd5, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 1 || nbad != 0 || rd !== 4'd5 || ro !== 1'b0) begin n_fail++;
      $display("FAIL load5 done=%0d nrun=%0d nbad=%0d rd=%h ro=%b exp 1/1/0/5/0", done, nrun, nbad, rd, ro); end
    run_cmd(2'b10, 4'd2, 3'd3, 2'b11, 4'd2, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 3 || nbad != 0) begin n_fail++; $display("FAIL sub2x3_timing done=%0d nrun=%0d nbad=%0d exp 1/3/0", done, nrun, nbad); end
    n_checks++; if (rd !== 4'hF || ro !== 1'b1) begin n_fail++; $display("FAIL sub2x3_res rd=%h ro=%b exp f/1", rd, ro); end
  endtask

  task automatic test_add_ovf();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    run_cmd(2'b11, 4'd0, 3'd0, 2'b01, 4'd0, nrun, nbad, ncyc, done, rd, ro);
    run_cmd(2'b01, 4'd9, 3'd2, 2'b10, 4'd9, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 2 || rd !== 4'd2 || ro !== 1'b1) begin n_fail++;
      $display("FAIL add9x2 done=%0d nrun=%0d rd=%h ro=%b exp 1/2/2/1", done, nrun, rd, ro); end
    run_cmd(2'b00, 4'd3, 3'd0, 2'b01, 4'd3, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || rd !== 4'd3 || ro !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared rd=%h ro=%b exp 3/0", rd, ro); end
  endtask

  task automatic test_cnt_zero();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    run_cmd(2'b01, 4'd7, 3'd0, 2'b10, 4'd7, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 0 || ncyc != 1) begin n_fail++; $display("FAIL add_cnt0_timing done=%0d nrun=%0d ncyc=%0d exp 1/0/1", done, nrun, ncyc); end
    n_checks++; if (rd !== 4'd3 || ro !== 1'b0) begin n_fail++; $display("FAIL add_cnt0_res rd=%h ro=%b exp 3/0", rd, ro); end
    run_cmd(2'b10, 4'd4, 3'd0, 2'b11, 4'd4, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 0 || rd !== 4'd3 || ro !== 1'b0) begin n_fail++;
      $display("FAIL sub_cnt0 done=%0d nrun=%0d rd=%h ro=%b exp 1/0/3/0", done, nrun, rd, ro); end
  endtask

  task automatic test_max_cnt();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    run_cmd(2'b01, 4'd1, 3'd7, 2'b10, 4'd1, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 7 || nbad != 0 || rd !== 4'hA || ro !== 1'b0) begin n_fail++;
      $display("FAIL add1x7 done=%0d nrun=%0d nbad=%0d rd=%h ro=%b exp 1/7/0/a/0", done, nrun, nbad, rd, ro); end
    run_cmd(2'b10, 4'd1, 3'd7, 2'b11, 4'd1, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || nrun != 7 || nbad != 0 || rd !== 4'd3 || ro !== 1'b0) begin n_fail++;
      $display("FAIL sub1x7 done=%0d nrun=%0d nbad=%0d rd=%h ro=%b exp 1/7/0/3/0", done, nrun, nbad, rd, ro); end
  endtask

  task automatic test_back_to_back();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    logic [15:0] rdy_v, stb_v;
    logic [3:0] rd1, rd2;
    int nstb;
    run_cmd(2'b11, 4'd0, 3'd0, 2'b01, 4'd0, nrun, nbad, ncyc, done, rd, ro);
    rdy_v = '0; stb_v = '0; rd1 = 4'hx; rd2 = 4'hx; nstb = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 4'd1; bus.cmd_cnt = 3'd3;
    for (int i = 0; i < 16; i++) begin
      rdy_v[i] = bus.cmd_ready;
      if (bus.res_valid === 1'b1) begin
        stb_v[i] = 1'b1;
        if (nstb == 0) rd1 = bus.res_data; else rd2 = bus.res_data;
        nstb++;
      end
      if (i == 6) bus.cmd_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (rdy_v !== 16'hFC21) begin n_fail++; $display("FAIL b2b_ready got=%h exp=fc21", rdy_v); end
    n_checks++; if (stb_v !== 16'h0210) begin n_fail++; $display("FAIL b2b_strobes got=%h exp=0210", stb_v); end
    n_checks++; if (rd1 !== 4'd3 || rd2 !== 4'd6) begin n_fail++; $display("FAIL b2b_results got=%h,%h exp=3,6", rd1, rd2); end
  endtask

  task automatic test_reset_mid_run();
    int nrun, nbad, ncyc; bit done; logic [3:0] rd; logic ro;
    int nstb;
    run_cmd(2'b11, 4'd0, 3'd0, 2'b01, 4'd0, nrun, nbad, ncyc, done, rd, ro);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 4'd1; bus.cmd_cnt = 3'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.dp_sel1, bus.dp_sel0} !== 2'b10 || bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL mid_run_pre sel=%b busy=%b exp 10/1", {bus.dp_sel1, bus.dp_sel0}, bus.busy); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({bus.dp_sel1, bus.dp_sel0} !== 2'b00 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin n_fail++;
      $display("FAIL mid_run_rst sel=%b busy=%b rv=%b rdy=%b exp 00/0/0/0", {bus.dp_sel1, bus.dp_sel0}, bus.busy, bus.res_valid, bus.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    nstb = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) nstb++;
      @(negedge clk);
    end
    n_checks++; if (nstb != 0) begin n_fail++; $display("FAIL mid_run_no_strobe got=%0d exp=0", nstb); end
    run_cmd(2'b01, 4'd0, 3'd0, 2'b10, 4'd0, nrun, nbad, ncyc, done, rd, ro);
    n_checks++; if (!done || rd !== 4'd2 || ro !== 1'b0) begin n_fail++; $display("FAIL acc_kept done=%0d rd=%h ro=%b exp 1/2/0", done, rd, ro); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 4'd0; bus.cmd_cnt = 3'd0;
    test_reset();
    test_clear_add();
    test_sub_borrow();
    test_add_ovf();
    test_cnt_zero();
    test_max_cnt();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
